// File: rtl/rr_priority_encoder_if.sv
// Handshake and data bundle for rr_priority_encoder: request side plus registered grant side.
// Handshake: a beat transfers on a rising edge where valid & ready are both high; a producer
// holding valid keeps its payload stable until that edge, and ready may depend on valid.
interface rr_pe_if #(
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(WIDTH);

  logic             i_flush;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_req;
  logic             i_rr_en;
  logic             o_valid;
  logic             i_ready;
  logic [IDX_W-1:0] o_idx;
  logic [WIDTH-1:0] o_onehot;
  logic             o_zero;

  modport slave (
    input  i_flush, i_valid, i_req, i_rr_en, i_ready,
    output o_ready, o_valid, o_idx, o_onehot, o_zero
  );

  modport master (
    output i_flush, i_valid, i_req, i_rr_en, i_ready,
    input  o_ready, o_valid, o_idx, o_onehot, o_zero
  );
endinterface

// File: rtl/rr_priority_encoder.sv
// Registered multi-hot priority encoder with fixed or round-robin priority and a single
// output stage; o_dbg_ptr exposes the round-robin pointer for observation.
module rr_priority_encoder #(
  parameter  int WIDTH     = 16,
  parameter  int RESET_PTR = 0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  rr_pe_if.slave           bus,
  output logic [IDX_W-1:0] o_dbg_ptr
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(RESET_PTR);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             accept;
  logic             req_any;
  logic [IDX_W-1:0] win;
  logic             found;
  int               j;

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;
  assign req_any     = |bus.i_req;

  // Scan starts at ptr (RR) or 0 (fixed) and wraps; first set bit wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < WIDTH; k++) begin
      j = bus.i_rr_en ? int'(ptr_q) + k : k;
      if (j >= WIDTH) j = j - WIDTH;
      if (!found && bus.i_req[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    zero_d   = zero_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    if (bus.i_flush) begin
      valid_d  = 1'b0;
      zero_d   = 1'b0;
      idx_d    = '0;
      onehot_d = '0;
      ptr_d    = PTR_RST;
    end else if (accept) begin
      valid_d  = 1'b1;
      zero_d   = !req_any;
      idx_d    = req_any ? win : '0;
      onehot_d = req_any ? (WIDTH'(1) << win) : '0;
      if (bus.i_rr_en && req_any) begin
        ptr_d = (win == IDX_MAX) ? '0 : win + 1'b1;
      end
    end else if (valid_q && bus.i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= PTR_RST;
    end else begin
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign bus.o_valid  = valid_q;
  assign bus.o_zero   = zero_q;
  assign bus.o_idx    = idx_q;
  assign bus.o_onehot = onehot_q;
  assign o_dbg_ptr    = ptr_q;

endmodule
